dcache_plru_ctrl: RTL and testbench

Per-set tree-PLRU state holder and victim selector for the 4-way data cache. It stores one 3-bit PLRU vector per set, applies hit/fill touches through the `plru_update` next-state function, and returns a registered victim way for each lookup. Victim selection prefers invalid ways. It sits between the dcache control FSM, which issues lookups and touches, and the way-select / writeback datapath, which consumes the victim.

---
 rtl/dcache_pkg.sv | 17 +
 rtl/plru_update.sv | 21 ++
 rtl/dcache_plru_ctrl.sv | 125 ++++++++++++
 tb/tb_dcache_plru_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types for the data-cache PLRU replacement logic.
// Holds the PLRU vector type, way index type, reset value and FSM states.
package dcache_pkg;

  localparam int NUM_WAYS = 4;

  typedef logic [2:0] plru_t;
  typedef logic [1:0] way_t;

  localparam plru_t PLRU_RESET = 3'b000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } plru_state_e;

endpackage

// File: rtl/plru_update.sv
// Tree-PLRU touch next-state: marks one way most-recently-used.
// Ports: cur (current vector), way (touched way), nxt (updated vector).
module plru_update
  import dcache_pkg::*;
(
  input  plru_t cur,
  input  way_t  way,
  output plru_t nxt
);

  always_comb begin
    nxt = cur;
    unique case (way)
      2'd0: nxt = {cur[2], 1'b1, 1'b1};
      2'd1: nxt = {cur[2], 1'b0, 1'b1};
      2'd2: nxt = {1'b1, cur[1], 1'b0};
      2'd3: nxt = {1'b0, cur[1], 1'b0};
    endcase
  end

endmodule

// File: rtl/dcache_plru_ctrl.sv
// Per-set tree-PLRU storage, touch update, flush sweep and victim select.
// Ports: clk, rst_n; lookup_valid/lookup_set/way_valid request a victim;
// touch_valid/touch_set/touch_way mark a way MRU; flush_req clears all
// sets one per cycle; ready is high in IDLE; victim_valid/victim_way are
// the registered result, one cycle after an accepted lookup.
module dcache_plru_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int S_INDEX  = $clog2(NUM_SETS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lookup_valid,
  input  logic [S_INDEX-1:0] lookup_set,
  input  logic [3:0]         way_valid,
  input  logic               touch_valid,
  input  logic [S_INDEX-1:0] touch_set,
  input  logic [1:0]         touch_way,
  input  logic               flush_req,
  output logic               ready,
  output logic               victim_valid,
  output logic [1:0]         victim_way
);

  localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);

  plru_state_e        state;
  logic [S_INDEX-1:0] cnt;
  plru_t              plru_q [NUM_SETS];

  plru_t              touch_nxt;
  plru_t              look_vec;
  logic               touch_go;
  logic               lookup_go;
  logic               flush_go;
  logic               wr_en;
  logic [S_INDEX-1:0] wr_set;
  plru_t              wr_data;

  function automatic way_t pick_victim(plru_t p, logic [3:0] v);
    way_t w;
    if (!v[0])      w = 2'd0;
    else if (!v[1]) w = 2'd1;
    else if (!v[2]) w = 2'd2;
    else if (!v[3]) w = 2'd3;
    else if (p[0])  w = p[2] ? 2'd3 : 2'd2;
    else            w = p[1] ? 2'd1 : 2'd0;
    return w;
  endfunction

  plru_update u_upd (
    .cur (plru_q[touch_set]),
    .way (touch_way),
    .nxt (touch_nxt)
  );

  assign ready     = (state == IDLE);
  assign flush_go  = ready & flush_req;
  assign touch_go  = ready & touch_valid & ~flush_req;
  assign lookup_go = ready & lookup_valid & ~flush_req;

  // A touch to the looked-up set in the same cycle is forwarded.
  assign look_vec = (touch_go && touch_set == lookup_set)
                  ? touch_nxt : plru_q[lookup_set];

  // Single write port shared by the flush sweep and touches.
  always_comb begin
    wr_en   = 1'b0;
    wr_set  = touch_set;
    wr_data = touch_nxt;
    unique case (1'b1)
      (state == FLUSH): begin
        wr_en   = 1'b1;
        wr_set  = cnt;
        wr_data = PLRU_RESET;
      end
      touch_go: wr_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++)
        plru_q[i] <= PLRU_RESET;
    end else if (wr_en) begin
      plru_q[wr_set] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush_go) begin
            state <= FLUSH;
            cnt   <= '0;
          end
        end
        FLUSH: begin
          cnt <= cnt + S_INDEX'(1);
          if (cnt == LAST_SET)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_valid <= 1'b0;
      victim_way   <= 2'd0;
    end else begin
      victim_valid <= lookup_go;
      if (lookup_go)
        victim_way <= pick_victim(look_vec, way_valid);
    end
  end

endmodule

// File: tb/tb_dcache_plru_ctrl.sv
// Directed self-checking bench for dcache_plru_ctrl.
module tb_dcache_plru_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lookup_valid = 1'b0;
  logic [3:0] lookup_set = '0;
  logic [3:0] way_valid = '0;
  logic       touch_valid = 1'b0;
  logic [3:0] touch_set = '0;
  logic [1:0] touch_way = '0;
  logic       flush_req = 1'b0;
  logic       ready;
  logic       victim_valid;
  logic [1:0] victim_way;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_plru_ctrl #(.NUM_SETS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_set   (lookup_set),
    .way_valid    (way_valid),
    .touch_valid  (touch_valid),
    .touch_set    (touch_set),
    .touch_way    (touch_way),
    .flush_req    (flush_req),
    .ready        (ready),
    .victim_valid (victim_valid),
    .victim_way   (victim_way)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    lookup_valid = 1'b0;
    touch_valid  = 1'b0;
    flush_req    = 1'b0;
  endtask

  task automatic touch(input logic [3:0] s, input logic [1:0] w);
    touch_valid = 1'b1;
    touch_set   = s;
    touch_way   = w;
    step();
    clear_in();
  endtask

  task automatic lookup(input logic [3:0] s, input logic [3:0] v);
    lookup_valid = 1'b1;
    lookup_set   = s;
    way_valid    = v;
    step();
    clear_in();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (ready !== 1'b1 || victim_valid !== 1'b0 || victim_way !== 2'd0) begin
      n_bad++;
      $display("FAIL reset: rdy=%b vv=%b vw=%0d want 1 0 0",
               ready, victim_valid, victim_way);
    end
    step();
    rst_n = 1'b1;
    step();
    lookup(4'd5, 4'b1111);
    n_cmp++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_lookup: vv=%b vw=%0d want 1 0",
               victim_valid, victim_way);
    end
    step();
    n_cmp++;
    if (victim_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL vv_pulse: vv=%b want 0", victim_valid);
    end
  endtask

  task automatic test_touch();
    touch(4'd3, 2'd0);
    lookup(4'd3, 4'b1111);
    n_cmp++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd2) begin
      n_bad++;
      $display("FAIL touch_way0: vv=%b vw=%0d want 1 2",
               victim_valid, victim_way);
    end
  endtask

  task automatic test_sequence();
    touch(4'd7, 2'd0);
    touch(4'd7, 2'd2);
    touch(4'd7, 2'd1);
    lookup(4'd7, 4'b1111);
    n_cmp++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd3) begin
      n_bad++;
      $display("FAIL touch_seq: vv=%b vw=%0d want 1 3",
               victim_valid, victim_way);
    end
  endtask

  task automatic test_bypass();
    touch_valid = 1'b1; touch_set = 4'd2; touch_way = 2'd2;
    lookup(4'd2, 4'b1111);
    n_cmp++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
      n_bad++;
      $display("FAIL bypass_s2: vv=%b vw=%0d want 1 0",
               victim_valid, victim_way);
    end
    touch(4'd4, 2'd0);
    touch_valid = 1'b1; touch_set = 4'd4; touch_way = 2'd2;
    lookup(4'd4, 4'b1111);
    n_cmp++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd1) begin
      n_bad++;
      $display("FAIL bypass_s4: vv=%b vw=%0d want 1 1",
               victim_valid, victim_way);
    end
  endtask

  task automatic test_invalid();
    touch(4'd9, 2'd2);
    lookup(4'd9, 4'b1011);
    n_cmp++;
    if (victim_way !== 2'd2) begin
      n_bad++;
      $display("FAIL inv_1011: vw=%0d want 2", victim_way);
    end
    lookup(4'd9, 4'b0111);
    n_cmp++;
    if (victim_way !== 2'd3) begin
      n_bad++;
      $display("FAIL inv_0111: vw=%0d want 3", victim_way);
    end
    lookup(4'd7, 4'b1101);
    n_cmp++;
    if (victim_way !== 2'd1) begin
      n_bad++;
      $display("FAIL inv_1101: vw=%0d want 1", victim_way);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] sets [3];
    logic [1:0] exp  [3];
    sets = '{4'd3, 4'd7, 4'd4};
    exp  = '{2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 3; i++) begin
      lookup_valid = 1'b1;
      lookup_set   = sets[i];
      way_valid    = 4'b1111;
      step();
      n_cmp++;
      if (victim_valid !== 1'b1 || victim_way !== exp[i]) begin
        n_bad++;
        $display("FAIL b2b_%0d: vv=%b vw=%0d want 1 %0d",
                 i, victim_valid, victim_way, exp[i]);
      end
    end
    clear_in();
  endtask

  task automatic test_flush();
    int n;
    touch(4'd10, 2'd1);
    flush_req   = 1'b1;
    touch_valid = 1'b1; touch_set = 4'd10; touch_way = 2'd0;
    lookup_valid = 1'b1; lookup_set = 4'd10; way_valid = 4'b1111;
    step();
    clear_in();
    n_cmp++;
    if (victim_valid !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_start: vv=%b rdy=%b want 0 0",
               victim_valid, ready);
    end
    n = 0;
    while (ready === 1'b0 && n < 40) begin
      n++;
      flush_req    = (n == 3);
      touch_valid  = (n == 10);
      touch_set    = 4'd0;
      touch_way    = 2'd0;
      lookup_valid = (n == 5);
      lookup_set   = 4'd3;
      step();
      n_cmp++;
      if (victim_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_novictim: cyc=%0d vv=%b want 0",
                 n, victim_valid);
      end
    end
    clear_in();
    n_cmp++;
    if (n != 16) begin
      n_bad++;
      $display("FAIL flush_len: low=%0d want 16", n);
    end
    for (int s = 0; s < 16; s++) begin
      lookup(4'(s), 4'b1111);
      n_cmp++;
      if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
        n_bad++;
        $display("FAIL post_flush_s%0d: vv=%b vw=%0d want 1 0",
                 s, victim_valid, victim_way);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    touch(4'd6, 2'd1);
    touch(4'd15, 2'd0);
    flush_req = 1'b1;
    step();
    clear_in();
    repeat (4) step();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (ready !== 1'b1 || victim_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst: rdy=%b vv=%b want 1 0",
               ready, victim_valid);
    end
    #1;
    rst_n = 1'b1;
    step();
    lookup(4'd15, 4'b1111);
    n_cmp++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_rst_s15: vv=%b vw=%0d want 1 0",
               victim_valid, victim_way);
    end
    lookup(4'd6, 4'b1111);
    n_cmp++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_rst_s6: vv=%b vw=%0d want 1 0",
               victim_valid, victim_way);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_touch();
    test_sequence();
    test_bypass();
    test_invalid();
    test_back_to_back();
    test_flush();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
